mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares the single-port, byte-addressed, little-endian 1 KB data memory between the instruction-fetch port and the load/store port of the CPU. It sits between both pipeline ports and the memory's MemRead/MemWrite/addr/wd/rd interface. It accepts one access at a time, drives the memory for exactly one cycle, and returns registered read data with a valid/error pulse. Misaligned or out-of-range accesses are rejected before they reach memory.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the fetch and load/store ports.
// One access per two cycles, round-robin on contention, bad addresses rejected early.
module mem_port_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        lastData_q, lastData_d;
  logic        winData_q, winData_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ifValid_q, ifValid_d;
  logic        ifErr_q, ifErr_d;
  logic        dValid_q, dValid_d;
  logic        dErr_q, dErr_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic [31:0] dRdata_q, dRdata_d;
  logic        pickData;
  logic [31:0] selAddr;

  always_comb begin
    pickData   = d_req && (!if_req || !lastData_q);
    selAddr    = pickData ? d_addr : if_addr;
    state_d    = state_q;
    lastData_d = lastData_q;
    winData_d  = winData_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ifValid_d  = 1'b0;
    ifErr_d    = 1'b0;
    dValid_d   = 1'b0;
    dErr_d     = 1'b0;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d    = ACCESS;
          lastData_d = pickData;
          winData_d  = pickData;
          we_d       = pickData && d_we;
          addr_d     = selAddr;
          wdata_d    = pickData ? d_wdata : 32'h0;
          // 33-bit sum so addresses near 2^32 are rejected instead of wrapping
          err_d      = (selAddr[1:0] != 2'b00) || (({1'b0, selAddr} + 33'd3) >= MemLimit);
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (winData_q) begin
          dValid_d = 1'b1;
          dErr_d   = err_q;
          dRdata_d = (err_q || we_q) ? 32'h0 : mem_rd;
        end else begin
          ifValid_d = 1'b1;
          ifErr_d   = err_q;
          ifRdata_d = err_q ? 32'h0 : mem_rd;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastData_q <= 1'b1;
      winData_q  <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      ifValid_q  <= 1'b0;
      ifErr_q    <= 1'b0;
      dValid_q   <= 1'b0;
      dErr_q     <= 1'b0;
      ifRdata_q  <= 32'h0;
      dRdata_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      lastData_q <= lastData_d;
      winData_q  <= winData_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ifValid_q  <= ifValid_d;
      ifErr_q    <= ifErr_d;
      dValid_q   <= dValid_d;
      dErr_q     <= dErr_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
    end
  end

  // Memory strobes come only from state and latched request, never from req inputs
  assign if_gnt   = (state_q == ACCESS) && !winData_q;
  assign d_gnt    = (state_q == ACCESS) && winData_q;
  assign MemRead  = (state_q == ACCESS) && !err_q && !we_q;
  assign MemWrite = (state_q == ACCESS) && !err_q && we_q;
  assign mem_addr = addr_q;
  assign mem_wd   = wdata_q;
  assign if_valid = ifValid_q;
  assign if_err   = ifErr_q;
  assign if_rdata = ifRdata_q;
  assign d_valid  = dValid_q;
  assign d_err    = dErr_q;
  assign d_rdata  = dRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_valid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Combinational-read, little-endian memory driven by the DUT
  logic [7:0] mem [0:MEM_BYTES-1];
  logic [9:0] rdIdx, wrIdx;
  logic       wrPend;
  logic [31:0] wrData;

  always_comb begin
    rdIdx  = mem_addr[9:0];
    mem_rd = {mem[rdIdx + 10'd3], mem[rdIdx + 10'd2], mem[rdIdx + 10'd1], mem[rdIdx]};
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    mem[16] <= 8'h78; mem[17] <= 8'h56; mem[18] <= 8'h34; mem[19] <= 8'h12;
    forever begin
      @(negedge clk);
      wrPend = MemWrite; wrIdx = mem_addr[9:0]; wrData = mem_wd;
      @(posedge clk);
      if (wrPend) begin
        mem[wrIdx]         <= wrData[7:0];
        mem[wrIdx + 10'd1] <= wrData[15:8];
        mem[wrIdx + 10'd2] <= wrData[23:16];
        mem[wrIdx + 10'd3] <= wrData[31:24];
      end
    end
  end

  // Reference model: one pending access and one pending response, byte array memory
  logic [7:0]  refMem [0:MEM_BYTES-1];
  bit          ready, mInReset, mLastData;
  bit          mAcc, mPort, mWe, mErr;
  bit          mResp, mRespPort, mRespErr;
  logic [31:0] mAddr, mWdata, mIfData, mDData;

  function automatic bit isBad(logic [31:0] a);
    return (a % 4 != 0) || (64'(a) + 64'd3 >= 64'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] refRead(logic [31:0] a);
    int b = int'(a[9:0]);
    return {refMem[b + 3], refMem[b + 2], refMem[b + 1], refMem[b]};
  endfunction

  task automatic refWrite(logic [31:0] a, logic [31:0] v);
    int b = int'(a[9:0]);
    for (int k = 0; k < 4; k++) refMem[b + k] = v[8*k +: 8];
  endtask

  task automatic modelStep();
    bit winData;
    if (!rst_n) begin
      if (mAcc && mWe && !mErr) refWrite(mAddr, mWdata);
      mAcc = 0; mResp = 0; mRespPort = 0; mRespErr = 0;
      mIfData = 0; mDData = 0; mLastData = 1; mInReset = 1; ready = 1;
    end else begin
      mInReset = 0;
      mResp = mAcc;
      if (mAcc) begin
        mRespPort = mPort; mRespErr = mErr;
        if (!mPort) mIfData = mErr ? 32'h0 : refRead(mAddr);
        else begin
          mDData = (mErr || mWe) ? 32'h0 : refRead(mAddr);
          if (mWe && !mErr) refWrite(mAddr, mWdata);
        end
        mAcc = 0;
      end else if (if_req || d_req) begin
        if (if_req && d_req) winData = !mLastData;
        else winData = d_req;
        mAcc = 1; mPort = winData; mLastData = winData;
        mAddr  = winData ? d_addr : if_addr;
        mWe    = winData && d_we;
        mWdata = d_wdata;
        mErr   = isBad(mAddr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h00;
    refMem[16] = 8'h78; refMem[17] = 8'h56; refMem[18] = 8'h34; refMem[19] = 8'h12;
    ready = 0; mAcc = 0; mResp = 0; mLastData = 1; mInReset = 0;
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareCycle();
    bit eRd, eWr;
    eRd = mAcc && !mErr && !mWe;
    eWr = mAcc && !mErr && mWe;
    checkOutput("if_gnt", 32'(if_gnt), 32'(mAcc && !mPort));
    checkOutput("d_gnt", 32'(d_gnt), 32'(mAcc && mPort));
    checkOutput("MemRead", 32'(MemRead), 32'(eRd));
    checkOutput("MemWrite", 32'(MemWrite), 32'(eWr));
    checkOutput("if_valid", 32'(if_valid), 32'(mResp && !mRespPort));
    checkOutput("d_valid", 32'(d_valid), 32'(mResp && mRespPort));
    if (mResp && !mRespPort) checkOutput("if_err", 32'(if_err), 32'(mRespErr));
    if (mResp && mRespPort) checkOutput("d_err", 32'(d_err), 32'(mRespErr));
    checkOutput("if_rdata", if_rdata, mIfData);
    checkOutput("d_rdata", d_rdata, mDData);
    if (eRd || eWr) checkOutput("mem_addr", mem_addr, mAddr);
    if (eWr) checkOutput("mem_wd", mem_wd, mWdata);
    if (mInReset) begin
      checkOutput("mem_addr reset", mem_addr, 32'h0);
      checkOutput("mem_wd reset", mem_wd, 32'h0);
    end
  endtask

  bit ifGntSeen, dGntSeen;

  initial begin
    ifGntSeen = 0; dGntSeen = 0;
    forever begin
      @(negedge clk);
      ifGntSeen = if_gnt; dGntSeen = d_gnt;
      if (ready) compareCycle();
    end
  end

  function automatic logic [31:0] randAddr();
    int sel = $urandom_range(0, 9);
    if (sel < 7) return 32'($urandom_range(0, 31)) << 2;
    if (sel == 7) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    if (sel == 8) return 32'h3F0 + 32'($urandom_range(0, 15));
    return 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
  endfunction

  // Protocol-compliant random requesters: hold until gnt, then drop or re-request
  task automatic applyStimulus();
    if (ifGntSeen) begin
      if ($urandom_range(0, 3) == 0) if_addr = randAddr();
      else if_req = 0;
    end else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = randAddr();
    end
    if (dGntSeen) begin
      if ($urandom_range(0, 3) == 0) begin
        d_addr = randAddr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end else d_req = 0;
    end else if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1; d_addr = randAddr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
    end
  endtask

  task automatic doAccess(input bit isData, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output bit err, output bit sawValid, output int rdCycles,
                          output int wrCycles);
    bit got = 0;
    rdCycles = 0; wrCycles = 0;
    @(posedge clk); #2;
    if (isData) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      rdCycles += int'(MemRead); wrCycles += int'(MemWrite);
      got = isData ? d_gnt : if_gnt;
    end
    checkOutput("gnt seen", 32'(got), 32'd1);
    @(posedge clk); #2;
    if_req = 0; d_req = 0;
    @(negedge clk);
    rdCycles += int'(MemRead); wrCycles += int'(MemWrite);
    sawValid = isData ? d_valid : if_valid;
    err      = isData ? d_err : if_err;
    rdata    = isData ? d_rdata : if_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] badAddr [3];
    logic [31:0] word;
    bit er, sv, got, drained;
    int rc, wc, nGnt, lastCyc;
    int gntCyc [6];
    bit gntPort [6];

    badAddr = '{32'h22, 32'h3FE, 32'hFFFFFFFC};
    rst_n = 0; if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 32'h0;

    // Reset with both requests held
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset if_gnt", 32'(if_gnt), 0);
    checkOutput("reset d_gnt", 32'(d_gnt), 0);
    checkOutput("reset MemRead", 32'(MemRead), 0);
    checkOutput("reset MemWrite", 32'(MemWrite), 0);
    checkOutput("reset valids", 32'({if_valid, d_valid, if_err, d_err}), 0);
    checkOutput("reset rdata", if_rdata | d_rdata, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    @(posedge clk); #2;
    rst_n = 1;
    rc = 0;
    @(negedge clk); rc += int'(MemRead);
    checkOutput("c0 if_gnt", 32'(if_gnt), 0);
    @(negedge clk); rc += int'(MemRead);
    checkOutput("c1 if_gnt", 32'(if_gnt), 1);
    checkOutput("c1 mem_addr", mem_addr, 32'h10);
    @(posedge clk); #2; if_req = 0;
    @(negedge clk); rc += int'(MemRead);
    checkOutput("c2 if_valid", 32'(if_valid), 1);
    checkOutput("c2 if_err", 32'(if_err), 0);
    checkOutput("c2 if_rdata", if_rdata, 32'h12345678);
    checkOutput("fetch MemRead cycles", 32'(rc), 1);
    @(negedge clk);
    checkOutput("c3 d_gnt", 32'(d_gnt), 1);
    @(posedge clk); #2; d_req = 0;
    @(negedge clk);
    checkOutput("c4 d_valid", 32'(d_valid), 1);

    // Store then load back
    doAccess(1, 1, 32'h20, 32'hDEADBEEF, rd, er, sv, rc, wc);
    checkOutput("store valid", 32'(sv), 1);
    checkOutput("store rdata", rd, 0);
    checkOutput("store err", 32'(er), 0);
    checkOutput("store MemWrite cycles", 32'(wc), 1);
    doAccess(1, 0, 32'h20, 32'h0, rd, er, sv, rc, wc);
    checkOutput("load valid", 32'(sv), 1);
    checkOutput("load rdata", rd, 32'hDEADBEEF);
    checkOutput("load MemRead cycles", 32'(rc), 1);

    // Rejected addresses never reach memory
    for (int i = 0; i < 3; i++) begin
      doAccess(1, 0, badAddr[i], 32'h0, rd, er, sv, rc, wc);
      checkOutput("bad valid", 32'(sv), 1);
      checkOutput("bad err", 32'(er), 1);
      checkOutput("bad rdata", rd, 0);
      checkOutput("bad strobes", 32'(rc + wc), 0);
    end
    doAccess(1, 0, 32'h3FC, 32'h0, rd, er, sv, rc, wc);
    checkOutput("top word err", 32'(er), 0);
    checkOutput("top word MemRead", 32'(rc), 1);

    // Continuous contention after reset alternates F, D starting with fetch
    @(posedge clk); #2; rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1; if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    nGnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((if_gnt || d_gnt) && nGnt < 6) begin
        gntCyc[nGnt] = c; gntPort[nGnt] = d_gnt; nGnt++;
      end
    end
    @(posedge clk); #2; if_req = 0; d_req = 0;
    checkOutput("grant count", 32'(nGnt), 6);
    lastCyc = -1;
    for (int i = 0; i < nGnt; i++) begin
      checkOutput("grant order", 32'(gntPort[i]), 32'(i % 2));
      checkOutput("grant gap ok", 32'(gntCyc[i] - lastCyc <= 2), 1);
      lastCyc = gntCyc[i];
    end

    // Reset arriving at the edge that ends a store
    repeat (2) @(posedge clk);
    #2; d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = d_gnt;
    end
    checkOutput("mid-reset gnt seen", 32'(got), 1);
    rst_n = 0;
    @(posedge clk); #2; d_req = 0;
    @(negedge clk);
    checkOutput("mid-reset d_valid", 32'(d_valid), 0);
    checkOutput("mid-reset MemWrite", 32'(MemWrite), 0);
    checkOutput("mid-reset d_rdata", d_rdata, 0);
    word = {mem[51], mem[50], mem[49], mem[48]};
    checkOutput("mid-reset mem word", word, 32'hCAFEF00D);
    @(posedge clk); #2; rst_n = 1;
    @(negedge clk);
    checkOutput("post-reset d_valid", 32'(d_valid), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      applyStimulus();
    end
    drained = 0;
    for (int c = 0; c < 50 && !drained; c++) begin
      @(posedge clk); #2;
      if (ifGntSeen) if_req = 0;
      if (dGntSeen) d_req = 0;
      drained = !if_req && !d_req;
    end
    checkOutput("drained", 32'(drained), 1);
    repeat (4) @(posedge clk);
    #2;
    rc = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== refMem[i]) rc++;
    checkOutput("memory image mismatched bytes", 32'(rc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
